// File: rtl/keypad_scan_if.sv
// keypad_scan_if: bundles the keypad matrix lines and the key event outputs.
//   key_col   column sense lines, active-low, driven by the board side
//   key_row   active-low one-hot row drive from the scanner
//   key_code  last accepted key code (row*4 + col)
//   key_valid one-cycle pulse when key_code updates
//   key_held  high from accept until debounced release
interface keypad_scan_if;
    logic [3:0] key_col;
    logic [3:0] key_row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    modport master (input key_col, output key_row, key_code, key_valid, key_held);
    modport slave (output key_col, input key_row, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 key matrix row scanner with frame-based debounce.
//   clk  system clock
//   rst  synchronous active-low reset
//   kp   keypad_scan_if.master: key_col in; key_row, key_code, key_valid, key_held out
module keypad_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 3
) (
    input logic          clk,
    input logic          rst,
    keypad_scan_if.master kp
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    localparam logic [3:0] DB = 4'(DEBOUNCE);

    typedef enum logic [1:0] {IDLE, CONFIRM, PRESSED, RELEASE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [1:0]    row_idx, acc_n, tot_n, col;
    logic [3:0]    acc_code, code, pressed, cand, cand_n, match, match_n, code_r;
    logic [2:0]    sum;
    logic          last, fe, one, none, accept, release_done, valid_r, held_r;

    // Fold the current row's sample into the running frame result.
    always_comb begin
        pressed = ~kp.key_col;
        sum = 3'(acc_n) + 3'(pressed[0]) + 3'(pressed[1]) + 3'(pressed[2]) + 3'(pressed[3]);
        tot_n = sum >= 3'd2 ? 2'd2 : sum[1:0];
        col = pressed[0] ? 2'd0 : pressed[1] ? 2'd1 : pressed[2] ? 2'd2 : 2'd3;
        code = acc_n == 2'd0 ? {row_idx, col} : acc_code;
        last = cnt == LAST;
        fe = last && row_idx == 2'd3;
        one = tot_n == 2'd1;
        none = tot_n == 2'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            row_idx <= 2'd0;
            acc_n <= 2'd0;
            acc_code <= 4'd0;
        end else begin
            cnt <= last ? '0 : cnt + CW'(1);
            if (last) begin
                row_idx <= row_idx + 2'd1;
                acc_n <= fe ? 2'd0 : tot_n;
                acc_code <= fe ? 4'd0 : code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cand <= 4'd0;
            match <= 4'd0;
            code_r <= 4'd0;
            valid_r <= 1'b0;
            held_r <= 1'b0;
        end else begin
            state <= state_n;
            cand <= cand_n;
            match <= match_n;
            code_r <= accept ? cand_n : code_r;
            valid_r <= accept;
            held_r <= accept ? 1'b1 : release_done ? 1'b0 : held_r;
        end
    end

    // The debounce FSM only advances on the frame-end edge.
    always_comb begin
        state_n = state;
        cand_n = cand;
        match_n = match;
        accept = 1'b0;
        release_done = 1'b0;
        if (fe) begin
            case (state)
                IDLE: if (one) begin
                    cand_n = code;
                    match_n = 4'd1;
                    accept = DB == 4'd1;
                    state_n = DB == 4'd1 ? PRESSED : CONFIRM;
                end
                CONFIRM: if (one && code == cand) begin
                    match_n = match + 4'd1;
                    accept = match_n == DB;
                    state_n = match_n == DB ? PRESSED : CONFIRM;
                end else if (one) begin
                    cand_n = code;
                    match_n = 4'd1;
                end else begin
                    state_n = IDLE;
                end
                PRESSED: if (none) begin
                    match_n = 4'd1;
                    release_done = DB == 4'd1;
                    state_n = DB == 4'd1 ? IDLE : RELEASE;
                end
                RELEASE: if (none) begin
                    match_n = match + 4'd1;
                    release_done = match_n == DB;
                    state_n = match_n == DB ? IDLE : RELEASE;
                end else begin
                    state_n = PRESSED;
                end
            endcase
        end
    end

    always_comb begin
        kp.key_row = ~(4'b0001 << row_idx);
        kp.key_code = code_r;
        kp.key_valid = valid_r;
        kp.key_held = held_r;
    end
endmodule
